// File: rtl/mig_cmd_arbiter.sv
// Round-robin arbiter sharing one MIG user command port between NUM_REQ requesters,
// with an in-order read tag FIFO routing read data back. Option: MIG_ARB_PRIO0_EN.
module mig_cmd_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128,
    parameter int MAX_RD  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_strb_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          mig_en_o,
    output logic                          mig_w_en_o,
    output logic [ADDR_W-1:0]             mig_addr_o,
    output logic [DATA_W-1:0]             mig_data_o,
    output logic [DATA_W/8-1:0]           mig_strb_o,
    input  logic                          mig_ready_i,
    input  logic                          mig_rvalid_i,
    input  logic [DATA_W-1:0]             mig_rdata_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_W-1:0]             rsp_data_o,
    output logic [$clog2(MAX_RD+1)-1:0]   rd_outstanding_o,
    output logic                          err_o
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(MAX_RD + 1);
    localparam int PTR_W  = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RD);

    logic [IDX_W-1:0]   rr_ptr, rr_next, grant_idx, sel_idx;
    logic [IDX_W:0]     cand_sum;
    logic [IDX_W-1:0]   cand;
    logic               grant_found, issue, push, pop;
    logic [NUM_REQ-1:0] eligible, rsp_onehot;
    logic [IDX_W-1:0]   tag_mem [MAX_RD];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    // A full tag FIFO blocks reads even if a pop lands in the same cycle.
    assign eligible = req_valid_i & (req_write_i | {NUM_REQ{count < CNT_MAX}});

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand_sum >= (IDX_W+1)'(NUM_REQ))
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            cand = cand_sum[IDX_W-1:0];
`ifdef MIG_ARB_PRIO0_EN
            if (!grant_found && cand != '0 && eligible[cand]) begin
`else
            if (!grant_found && eligible[cand]) begin
`endif
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
`ifdef MIG_ARB_PRIO0_EN
        if (eligible[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
        end
`endif
    end

    // Handshake: a command transfers in the cycle where mig_en_o is high, which
    // already includes mig_ready_i; req_ready_o is the same-cycle accept pulse.
    assign issue   = grant_found && mig_ready_i;
    assign sel_idx = grant_found ? grant_idx : '0;
    assign rr_next = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        mig_addr_o  = '0;
        mig_data_o  = '0;
        mig_strb_o  = '0;
        req_ready_o = '0;
        mig_w_en_o  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_idx == IDX_W'(k)) begin
                mig_addr_o = req_addr_i[k*ADDR_W +: ADDR_W];
                mig_data_o = req_data_i[k*DATA_W +: DATA_W];
                mig_strb_o = req_strb_i[k*STRB_W +: STRB_W];
                req_ready_o[k] = issue;
                mig_w_en_o     = issue && req_write_i[k];
            end
        end
    end

    assign mig_en_o         = issue;
    assign push             = issue && !mig_w_en_o;
    assign pop              = mig_rvalid_i && (count != '0);
    assign rd_outstanding_o = count;

    always_comb begin
        rsp_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (tag_mem[rd_ptr] == IDX_W'(k)) rsp_onehot[k] = 1'b1;
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_RD-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            err_o       <= 1'b0;
            for (int i = 0; i < MAX_RD; i++) tag_mem[i] <= '0;
        end else begin
            if (issue) begin
`ifdef MIG_ARB_PRIO0_EN
                if (grant_idx != '0) rr_ptr <= rr_next;
`else
                rr_ptr <= rr_next;
`endif
            end
            if (push) begin
                tag_mem[wr_ptr] <= grant_idx;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            rsp_valid_o <= pop ? rsp_onehot : '0;
            if (pop) rsp_data_o <= mig_rdata_i;
            if (mig_rvalid_i && count == '0) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mig_cmd_arbiter.sv
// Scoreboard bench for mig_cmd_arbiter: directed requester command lists, expected
// issue and response queues checked by a negedge monitor.
module tb_mig_cmd_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 28;
  localparam int DATA_W  = 128;
  localparam int MAX_RD  = 4;
  localparam int STRB_W  = DATA_W / 8;
  localparam int CNT_W   = $clog2(MAX_RD + 1);
  localparam int CMD_W   = 1 + ADDR_W + DATA_W;
  localparam int ISS_W   = 3 + CMD_W;
  localparam int RSP_W   = NUM_REQ + DATA_W + 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_write = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ*STRB_W-1:0] req_strb = '0;
  logic                      mig_ready = 1'b1;
  logic                      mig_rvalid = 1'b0;
  logic [DATA_W-1:0]         mig_rdata = '0;

  logic [NUM_REQ-1:0] req_ready_o, rsp_valid_o;
  logic               mig_en_o, mig_w_en_o, err_o;
  logic [ADDR_W-1:0]  mig_addr_o;
  logic [DATA_W-1:0]  mig_data_o, rsp_data_o;
  logic [STRB_W-1:0]  mig_strb_o;
  logic [CNT_W-1:0]   rd_outstanding_o;

  logic [CMD_W-1:0] cmd_q0[$];
  logic [CMD_W-1:0] cmd_q1[$];
  logic [ISS_W-1:0] exp_iss_q[$];
  logic [RSP_W-1:0] exp_rsp_q[$];
  logic [NUM_REQ-1:0] ready_seen = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mig_cmd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_strb_i(req_strb), .req_ready_o(req_ready_o),
    .mig_en_o(mig_en_o), .mig_w_en_o(mig_w_en_o), .mig_addr_o(mig_addr_o),
    .mig_data_o(mig_data_o), .mig_strb_o(mig_strb_o), .mig_ready_i(mig_ready),
    .mig_rvalid_i(mig_rvalid), .mig_rdata_i(mig_rdata),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .rd_outstanding_o(rd_outstanding_o), .err_o(err_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    return {4{4'hD, a}};
  endfunction

  // driver tasks
  task automatic add_cmd(input int k, input bit w, input logic [ADDR_W-1:0] a);
    if (k == 0) cmd_q0.push_back({w, a, data_of(a)});
    else        cmd_q1.push_back({w, a, data_of(a)});
  endtask

  task automatic exp_iss(input int k, input bit w, input logic [ADDR_W-1:0] a);
    exp_iss_q.push_back({3'(k), w, a, data_of(a)});
  endtask

  task automatic load_next(input int k);
    logic [CMD_W-1:0] c;
    if ((k == 0 && cmd_q0.size() == 0) || (k == 1 && cmd_q1.size() == 0)) begin
      req_valid[k] = 1'b0;
    end else begin
      c = (k == 0) ? cmd_q0.pop_front() : cmd_q1.pop_front();
      req_valid[k] = 1'b1;
      req_write[k] = c[CMD_W-1];
      req_addr[k*ADDR_W +: ADDR_W] = c[DATA_W +: ADDR_W];
      req_data[k*DATA_W +: DATA_W] = c[DATA_W-1:0];
      req_strb[k*STRB_W +: STRB_W] = c[STRB_W-1:0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mig_rvalid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!req_valid[k] || ready_seen[k]) load_next(k);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic rvalid_pulse(input logic [DATA_W-1:0] d, input logic [NUM_REQ-1:0] oh, input bit expect_rsp);
    step();
    mig_rvalid = 1'b1;
    mig_rdata  = d;
    if (expect_rsp) exp_rsp_q.push_back({oh, d, 32'(cyc + 1)});
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while ((exp_iss_q.size() != 0 || req_valid != '0) && n < budget);
    checks++;
    if (exp_iss_q.size() != 0 || req_valid != '0) begin
      errors++;
      $display("FAIL %s_timeout pending_issues=%0d required=0", name, exp_iss_q.size());
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [ISS_W-1:0] ei;
    logic [RSP_W-1:0] er;
    logic [NUM_REQ-1:0] oh;
    ready_seen = req_ready_o;
    if (rst_n) begin
      if (mig_en_o) begin
        if (exp_iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue addr=%0h required=none", mig_addr_o);
        end else begin
          ei = exp_iss_q.pop_front();
          oh = '0;
          oh[ei[ISS_W-1 -: 3]] = 1'b1;
          chk("iss_ready", DATA_W'(req_ready_o), DATA_W'(oh));
          chk("iss_wen", DATA_W'(mig_w_en_o), DATA_W'(ei[CMD_W-1]));
          chk("iss_addr", DATA_W'(mig_addr_o), DATA_W'(ei[DATA_W +: ADDR_W]));
          if (ei[CMD_W-1]) begin
            chk("iss_data", mig_data_o, ei[DATA_W-1:0]);
            chk("iss_strb", DATA_W'(mig_strb_o), DATA_W'(ei[STRB_W-1:0]));
          end
        end
      end
      if (rsp_valid_o != '0) begin
        if (exp_rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp valid=%0b required=0", rsp_valid_o);
        end else begin
          er = exp_rsp_q.pop_front();
          chk("rsp_valid", DATA_W'(rsp_valid_o), DATA_W'(er[RSP_W-1 -: NUM_REQ]));
          chk("rsp_data", rsp_data_o, er[32 +: DATA_W]);
          chk("rsp_latency", DATA_W'(cyc), DATA_W'(er[31:0]));
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_rd_out"}, DATA_W'(rd_outstanding_o), '0);
    chk({tag, "_rsp_valid"}, DATA_W'(rsp_valid_o), '0);
    chk({tag, "_rsp_data"}, rsp_data_o, '0);
    chk({tag, "_err"}, DATA_W'(err_o), '0);
    chk({tag, "_mig_en"}, DATA_W'(mig_en_o), '0);
    chk({tag, "_req_ready"}, DATA_W'(req_ready_o), '0);
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    check_reset_state("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // both requesters hold writes, MIG always ready
    add_cmd(0, 1, 28'h0000100); add_cmd(0, 1, 28'h0000101);
    add_cmd(1, 1, 28'h0000200); add_cmd(1, 1, 28'h0000201);
`ifdef MIG_ARB_PRIO0_EN
    exp_iss(0, 1, 28'h0000100); exp_iss(0, 1, 28'h0000101);
    exp_iss(1, 1, 28'h0000200); exp_iss(1, 1, 28'h0000201);
`else
    exp_iss(0, 1, 28'h0000100); exp_iss(1, 1, 28'h0000200);
    exp_iss(0, 1, 28'h0000101); exp_iss(1, 1, 28'h0000201);
`endif
    wait_drained("rr_writes", 20);

    // read from 1 then from 0; data routed back in order
    add_cmd(1, 0, 28'h0000040); exp_iss(1, 0, 28'h0000040);
    run(2);
    add_cmd(0, 0, 28'h0000080); exp_iss(0, 0, 28'h0000080);
    run(3);
    @(negedge clk);
    chk("two_reads_outstanding", DATA_W'(rd_outstanding_o), DATA_W'(2));
    rvalid_pulse(128'hD1D1_0000_0000_0000_0000_0000_0000_00D1, 2'b10, 1'b1);
    rvalid_pulse(128'hD2D2_0000_0000_0000_0000_0000_0000_00D2, 2'b01, 1'b1);
    run(2);
    @(negedge clk);
    chk("reads_drained", DATA_W'(rd_outstanding_o), '0);

    // five reads against a four-deep tag FIFO
    for (int i = 0; i < 5; i++) begin
      add_cmd(0, 0, 28'h0000300 + 28'(i));
      exp_iss(0, 0, 28'h0000300 + 28'(i));
    end
    run(8);
    @(negedge clk);
    chk("full_rd_out", DATA_W'(rd_outstanding_o), DATA_W'(MAX_RD));
    chk("full_stall_ready", DATA_W'(req_ready_o), '0);
    chk("full_stall_en", DATA_W'(mig_en_o), '0);
    chk("full_stall_wen", DATA_W'(mig_w_en_o), '0);
    chk("full_stall_mux_addr", DATA_W'(mig_addr_o), DATA_W'(28'h0000304));
    rvalid_pulse(128'h3333, 2'b01, 1'b1);
    @(negedge clk);
    chk("pop_cycle_ready", DATA_W'(req_ready_o), '0);
    chk("pop_cycle_rd_out", DATA_W'(rd_outstanding_o), DATA_W'(MAX_RD));
    step();
    @(negedge clk);
    chk("after_pop_ready", DATA_W'(req_ready_o), DATA_W'(2'b01));
    chk("after_pop_rd_out", DATA_W'(rd_outstanding_o), DATA_W'(MAX_RD - 1));
    for (int i = 0; i < 4; i++) rvalid_pulse(128'h4440 + 128'(i), 2'b01, 1'b1);
    run(2);
    @(negedge clk);
    chk("full_drained", DATA_W'(rd_outstanding_o), '0);

    // MIG not ready for three cycles: nothing issues, pointer holds
    mig_ready = 1'b0;
    add_cmd(0, 1, 28'h0000500); add_cmd(1, 1, 28'h0000600);
`ifdef MIG_ARB_PRIO0_EN
    exp_iss(0, 1, 28'h0000500); exp_iss(1, 1, 28'h0000600);
`else
    exp_iss(1, 1, 28'h0000600); exp_iss(0, 1, 28'h0000500);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("not_ready_en", DATA_W'(mig_en_o), '0);
      chk("not_ready_req_ready", DATA_W'(req_ready_o), '0);
    end
    step();
    mig_ready = 1'b1;
    wait_drained("after_not_ready", 20);

`ifdef MIG_ARB_PRIO0_EN
    // requester 0 keeps priority while valid
    add_cmd(0, 1, 28'h0000800); add_cmd(0, 1, 28'h0000801); add_cmd(0, 1, 28'h0000802);
    add_cmd(1, 1, 28'h0000900);
    exp_iss(0, 1, 28'h0000800); exp_iss(0, 1, 28'h0000801); exp_iss(0, 1, 28'h0000802);
    exp_iss(1, 1, 28'h0000900);
    wait_drained("prio0", 20);
`endif

    // read outstanding, reset mid-operation, then late data raises err_o
    add_cmd(1, 0, 28'h0000700); exp_iss(1, 0, 28'h0000700);
    run(3);
    @(negedge clk);
    chk("pre_reset_rd_out", DATA_W'(rd_outstanding_o), DATA_W'(1));
    @(posedge clk); #1 rst_n = 1'b0;
    check_reset_state("mid_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    rvalid_pulse(128'hBAD, 2'b00, 1'b0);
    step();
    @(negedge clk);
    chk("late_data_err", DATA_W'(err_o), DATA_W'(1));
    chk("late_data_rsp_valid", DATA_W'(rsp_valid_o), '0);
    run(3);
    @(negedge clk);
    chk("err_sticky", DATA_W'(err_o), DATA_W'(1));
    chk("err_rd_out", DATA_W'(rd_outstanding_o), '0);

    chk("iss_queue_empty", DATA_W'(exp_iss_q.size()), '0);
    chk("rsp_queue_empty", DATA_W'(exp_rsp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mig_cmd_arbiter.md
Name: mig_cmd_arbiter

Overview:
- Shares one MIG user command port between NUM_REQ requesters, e.g. the APB bridge plus a scrub/init engine.
- Round-robin grant. Requests issue in order to the MIG.
- Tracks outstanding reads in an in-order tag FIFO, so each read response returns to the requester that issued it.
- Lives entirely in the MIG clock domain, between the request sources and the MIG user interface.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 28, MIG address width
- DATA_W, 128, MIG data width
- MAX_RD, 4, max outstanding reads; tag FIFO depth (power of 2)

Ports:
- clk_i  in  1  MIG user clock
- rst_ni  in  1  async active-low reset
- req_valid_i  in  NUM_REQ  per-requester command valid
- req_write_i  in  NUM_REQ  1=write, 0=read
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
- req_data_i  in  NUM_REQ*DATA_W  packed write data
- req_strb_i  in  NUM_REQ*DATA_W/8  packed byte enables
- req_ready_o  out  NUM_REQ  one-hot accept strobe
- mig_en_o  out  1  command issue strobe
- mig_w_en_o  out  1  write qualifier, valid with mig_en_o
- mig_addr_o  out  ADDR_W  issued address
- mig_data_o  out  DATA_W  issued write data
- mig_strb_o  out  DATA_W/8  issued byte enables
- mig_ready_i  in  1  MIG accepts command this cycle
- mig_rvalid_i  in  1  read data valid from MIG
- mig_rdata_i  in  DATA_W  read data from MIG
- rsp_valid_o  out  NUM_REQ  one-hot read response strobe
- rsp_data_o  out  DATA_W  read response data, shared bus
- rd_outstanding_o  out  $clog2(MAX_RD+1)  current outstanding read count
- err_o  out  1  sticky: read data arrived with no read outstanding

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr=0, tag FIFO empty, count=0, rsp_valid_o=0, rsp_data_o=0, err_o=0.
  - Combinational outputs follow from that state: req_ready_o=0, mig_en_o=0.
- Eligibility: requester k is eligible when req_valid_i[k] && (req_write_i[k] || count<MAX_RD).
  - A read is never eligible while count==MAX_RD, even if a pop occurs in the same cycle.
- Grant (combinational): the first eligible k searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- Issue = mig_ready_i && a grant exists. On issue:
  - mig_en_o=1; mig_w_en_o=req_write_i[g]; addr/data/strb muxed from g.
  - req_ready_o[g]=1. Zero-latency, same cycle.
  - rr_ptr <= (g+1) mod NUM_REQ.
- No issue:
  - mig_en_o=0, mig_w_en_o=0, req_ready_o=0, rr_ptr unchanged.
  - Mux outputs still show the current grant candidate, or requester 0 if there is none.
- Requester contract:
  - Holds valid and payload stable until its req_ready_o bit is seen.
  - Dropping valid before acceptance is illegal.
- Read issue: push g into the tag FIFO; count+1.
- Response, 1-cycle registered latency:
  - On mig_rvalid_i with FIFO non-empty: pop the head tag t; next cycle rsp_valid_o[t]=1 and rsp_data_o=mig_rdata_i; count-1.
  - rsp_data_o holds its last value otherwise.
- Same-cycle read push and pop: count unchanged; pointers advance independently.
- mig_rvalid_i with FIFO empty: no pop, rsp_valid_o stays 0, err_o<=1 until reset.
- Writes produce no response and do not touch the FIFO.
- MIG returns read data in command order; the arbiter relies on this.
- Mid-operation reset: all outstanding tags are discarded. Late MIG data after release sets err_o.

Optional Feature:
- Macro: MIG_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. It is granted whenever eligible, regardless of rr_ptr. The remaining requesters round-robin among themselves. A grant to requester 0 does not update rr_ptr.
- Undefined: pure round-robin over all NUM_REQ as above.

Test Plan:
- NUM_REQ=2, both hold valid writes, mig_ready_i=1 constantly:
  - grants alternate 0,1,0,1;
  - mig_w_en_o=1 on every issue;
  - addresses match the granted requester.
- Requester 1 issues read addr 0x40, then requester 0 issues read 0x80; MIG returns D1, then D2:
  - rsp_valid_o=2'b10 with D1, then 2'b01 with D2;
  - each response is one cycle after its mig_rvalid_i.
- MAX_RD=4, 5 reads back-to-back with no rvalid:
  - 4 issue, rd_outstanding_o=4, 5th stalls with req_ready_o=0;
  - 1 rvalid lets the 5th issue on the next cycle.
- mig_ready_i=0 for 3 cycles with both valid:
  - no mig_en_o, rr_ptr frozen;
  - first issue after ready rises goes to the prior rr_ptr.
- rvalid pulse after reset with nothing outstanding: err_o=1 and remains 1; rsp_valid_o=0.
- With MIG_ARB_PRIO0_EN, requester 0 valid continuously and requester 1 valid: only requester 0 granted until it drops valid.
